// File: rtl/ddr3_arb_pkg.sv
// Shared helpers for the DDR3 Wishbone arbiter: tag-width rule and the
// round-robin winner search used to pick the next requester.
package ddr3_arb_pkg;

  localparam int MAX_MASTERS = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // Tag width never collapses to zero bits, even for a single requester.
  function automatic int id_bits(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  // First eligible index searching cyclically from last+1; scanning
  // backwards lets the nearest candidate overwrite the farther ones.
  function automatic pick_t rr_pick(input logic [MAX_MASTERS-1:0] eligible,
                                    input logic [2:0] last, input int n);
    pick_t      p;
    logic [2:0] idx;
    p = '0;
    for (int i = MAX_MASTERS; i >= 1; i--) begin
      if (i <= n) begin
        idx = 3'((int'(last) + i) % n);
        if (eligible[idx]) begin
          p.found = 1'b1;
          p.idx   = idx;
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/ddr3_arb_credit.sv
// Per-master outstanding-request tracker: live credits (cnt) and acks still
// owed to an aborted cycle (stale), which must be swallowed before reuse.
module ddr3_arb_credit #(
  parameter  int MAX_OUTSTANDING = 15,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic cyc,
  input  logic inc,
  input  logic ack,
  output logic credit_ok,
  output logic busy_next,
  output logic route
);

  logic [CW-1:0] cnt_reg, cnt_next, stale_reg, stale_next;
  logic [CW-1:0] cnt_adj, stale_adj;
  logic          stale_nz;
  logic          dec;

  always_comb begin
    stale_nz  = (stale_reg != '0);
    dec       = ack && !stale_nz && (cnt_reg != '0);
    cnt_adj   = cnt_reg + CW'(inc) - CW'(dec);
    stale_adj = stale_reg - CW'(ack && stale_nz);
    if (cyc) begin
      cnt_next   = cnt_adj;
      stale_next = stale_adj;
    end else begin
      // Everything in flight for a dropped cycle becomes debt to discard.
      cnt_next   = '0;
      stale_next = stale_adj + cnt_adj;
    end
  end

  assign credit_ok = (cnt_reg < CW'(MAX_OUTSTANDING)) && !stale_nz;
  assign route     = ack && !stale_nz && cyc;
  assign busy_next = (cnt_next != '0) || (stale_next != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg   <= '0;
      stale_reg <= '0;
    end else begin
      cnt_reg   <= cnt_next;
      stale_reg <= stale_next;
    end
  end

endmodule

// File: rtl/ddr3_wb_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone port among several
// masters; master IDs ride in the low aux bits to route acks back.
module ddr3_wb_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter  int NUM_MASTERS     = 2,
  parameter  int ADDR_BITS       = 24,
  parameter  int DATA_BITS       = 512,
  parameter  int AUX_WIDTH       = 16,
  parameter  int MAX_OUTSTANDING = 15,
  localparam int SEL_BITS        = DATA_BITS / 8,
  localparam int ID_BITS         = id_bits(NUM_MASTERS),
  localparam int TAG_BITS        = AUX_WIDTH + ID_BITS
) (
  input  logic                             i_controller_clk,
  input  logic                             i_rst,
  input  logic [NUM_MASTERS-1:0]           i_m_cyc,
  input  logic [NUM_MASTERS-1:0]           i_m_stb,
  input  logic [NUM_MASTERS-1:0]           i_m_we,
  input  logic [NUM_MASTERS*ADDR_BITS-1:0] i_m_addr,
  input  logic [NUM_MASTERS*DATA_BITS-1:0] i_m_data,
  input  logic [NUM_MASTERS*SEL_BITS-1:0]  i_m_sel,
  input  logic [NUM_MASTERS*AUX_WIDTH-1:0] i_m_aux,
  output logic [NUM_MASTERS-1:0]           o_m_stall,
  output logic [NUM_MASTERS-1:0]           o_m_ack,
  output logic [DATA_BITS-1:0]             o_m_data,
  output logic [AUX_WIDTH-1:0]             o_m_aux,
  output logic                             o_wb_cyc,
  output logic                             o_wb_stb,
  output logic                             o_wb_we,
  output logic [ADDR_BITS-1:0]             o_wb_addr,
  output logic [DATA_BITS-1:0]             o_wb_data,
  output logic [SEL_BITS-1:0]              o_wb_sel,
  output logic [TAG_BITS-1:0]              o_wb_aux,
  input  logic                             i_wb_stall,
  input  logic                             i_wb_ack,
  input  logic [DATA_BITS-1:0]             i_wb_data,
  input  logic [TAG_BITS-1:0]              i_wb_aux
);

  logic [MAX_MASTERS-1:0] eligible;
  logic [NUM_MASTERS-1:0] credit_ok, busy_next, route;
  pick_t                  pick;
  logic                   load, req_valid_reg, req_valid_next, cyc_reg;
  logic [2:0]             last_reg;
  logic [ID_BITS-1:0]     ack_id;
  logic                   win_we;
  logic [ADDR_BITS-1:0]   win_addr;
  logic [DATA_BITS-1:0]   win_data;
  logic [SEL_BITS-1:0]    win_sel;
  logic [AUX_WIDTH-1:0]   win_aux;

  assign ack_id = i_wb_aux[ID_BITS-1:0];

  always_comb begin
    eligible = '0;
    for (int k = 0; k < NUM_MASTERS; k++)
      eligible[k] = i_m_cyc[k] && i_m_stb[k] && credit_ok[k];
    pick = rr_pick(eligible, last_reg, NUM_MASTERS);
    // Gating with reset keeps every master stalled while reset is held.
    load = pick.found && (!req_valid_reg || !i_wb_stall) && !i_rst;
    req_valid_next = load || (req_valid_reg && i_wb_stall);
  end

  always_comb begin
    win_we   = 1'b0;
    win_addr = '0;
    win_data = '0;
    win_sel  = '0;
    win_aux  = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (pick.idx == 3'(k)) begin
        win_we   = i_m_we[k];
        win_addr = i_m_addr[k*ADDR_BITS +: ADDR_BITS];
        win_data = i_m_data[k*DATA_BITS +: DATA_BITS];
        win_sel  = i_m_sel[k*SEL_BITS +: SEL_BITS];
        win_aux  = i_m_aux[k*AUX_WIDTH +: AUX_WIDTH];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      ddr3_arb_credit #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_credit (
        .clk       (i_controller_clk),
        .rst       (i_rst),
        .cyc       (i_m_cyc[gi]),
        .inc       (load && (pick.idx == 3'(gi))),
        .ack       (i_wb_ack && (ack_id == ID_BITS'(gi))),
        .credit_ok (credit_ok[gi]),
        .busy_next (busy_next[gi]),
        .route     (route[gi])
      );
      assign o_m_stall[gi] = !(load && (pick.idx == 3'(gi)));
    end
  endgenerate

  assign o_wb_stb = req_valid_reg;
  assign o_wb_cyc = cyc_reg;

  always_ff @(posedge i_controller_clk or posedge i_rst) begin
    if (i_rst) begin
      req_valid_reg <= 1'b0;
      cyc_reg       <= 1'b0;
      last_reg      <= 3'(NUM_MASTERS - 1);
      o_wb_we       <= 1'b0;
      o_wb_addr     <= '0;
      o_wb_data     <= '0;
      o_wb_sel      <= '0;
      o_wb_aux      <= '0;
    end else begin
      req_valid_reg <= req_valid_next;
      cyc_reg       <= req_valid_next || (|busy_next);
      if (load) begin
        last_reg  <= pick.idx;
        o_wb_we   <= win_we;
        o_wb_addr <= win_addr;
        o_wb_data <= win_data;
        o_wb_sel  <= win_sel;
        o_wb_aux  <= {win_aux, pick.idx[ID_BITS-1:0]};
      end
    end
  end

  always_ff @(posedge i_controller_clk or posedge i_rst) begin
    if (i_rst) begin
      o_m_ack  <= '0;
      o_m_data <= '0;
      o_m_aux  <= '0;
    end else begin
      o_m_ack <= route;
      if (i_wb_ack) begin
        o_m_data <= i_wb_data;
        o_m_aux  <= i_wb_aux[TAG_BITS-1:ID_BITS];
      end
    end
  end

endmodule

// File: tb/tb_ddr3_wb_arbiter.sv
// Bench for ddr3_wb_arbiter: two streaming masters, a FIFO controller model
// with throttled acks, and per-master scoreboards of expected responses.
module tb_ddr3_wb_arbiter;

  typedef struct packed { logic [7:0] aux; logic [31:0] data; } exp_t;
  typedef struct packed { logic id; logic [15:0] addr; } req_t;
  typedef struct packed { logic [8:0] tag; logic [15:0] addr; } pend_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  m_cyc = 2'b00;
  logic [1:0]  m_stb;
  logic [15:0] m_addr [2] = '{16'h0000, 16'h1000};
  logic [7:0]  m_aux  [2] = '{8'h01, 8'h41};
  logic [31:0] flat_addr;
  logic [15:0] flat_aux;
  logic [63:0] flat_data = 64'h1111_1111_0000_0000;
  logic [7:0]  flat_sel  = 8'hFF;
  logic [1:0]  m_stall, m_ack;
  logic [31:0] m_rdata;
  logic [7:0]  m_raux;
  logic        wb_cyc, wb_stb, wb_we;
  logic [15:0] wb_addr;
  logic [31:0] wb_data;
  logic [3:0]  wb_sel;
  logic [8:0]  wb_aux;
  logic        wb_stall = 1'b0;
  logic        wb_ack = 1'b0;
  logic [31:0] wb_rdata = '0;
  logic [8:0]  wb_raux = '0;

  int target [2] = '{0, 0};
  int issued [2] = '{0, 0};
  int ack_total [2] = '{0, 0};
  int ack_limit = 0, acks_sent = 0;
  int flush_gen = 0, seen_gen = 0;
  int last_grant = 1, coincide = 0;
  bit grant_chk_en = 0, cnt_chk_en = 0;
  int checks = 0, errors = 0;

  exp_t  sb [2][$];
  req_t  req_exp [$];
  pend_t pending [$];

  assign flat_addr = {m_addr[1], m_addr[0]};
  assign flat_aux  = {m_aux[1], m_aux[0]};
  assign m_stb[0]  = m_cyc[0] && (issued[0] < target[0]);
  assign m_stb[1]  = m_cyc[1] && (issued[1] < target[1]);

  always #5 clk = ~clk;

  ddr3_wb_arbiter #(
    .NUM_MASTERS(2), .ADDR_BITS(16), .DATA_BITS(32), .AUX_WIDTH(8), .MAX_OUTSTANDING(4)
  ) dut (
    .i_controller_clk(clk), .i_rst(rst),
    .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(2'b00),
    .i_m_addr(flat_addr), .i_m_data(flat_data), .i_m_sel(flat_sel), .i_m_aux(flat_aux),
    .o_m_stall(m_stall), .o_m_ack(m_ack), .o_m_data(m_rdata), .o_m_aux(m_raux),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr),
    .o_wb_data(wb_data), .o_wb_sel(wb_sel), .o_wb_aux(wb_aux),
    .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_data(wb_rdata), .i_wb_aux(wb_raux)
  );

  function automatic logic [31:0] rd_data(input logic [15:0] a);
    return {a, ~a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Master drivers, controller model and scoreboards in one agent process.
  initial begin : agent
    logic [1:0] acc;
    exp_t  e;
    req_t  r;
    pend_t p;
    forever begin
      @(negedge clk);
      acc = 2'b00;
      if (rst) begin
        sb[0].delete(); sb[1].delete(); req_exp.delete(); pending.delete();
        last_grant = 1;
      end else begin
        if (flush_gen != seen_gen) begin
          sb[1].delete();
          seen_gen = flush_gen;
        end
        for (int k = 0; k < 2; k++) begin
          if (m_ack[k]) begin
            ack_total[k]++;
            if (sb[k].size() == 0) chk("ack_unexpected", 1, 0);
            else begin
              e = sb[k].pop_front();
              chk("ack_aux", m_raux, e.aux);
              chk("ack_data", m_rdata, e.data);
              $display("ack m%0d aux %h data %h", k, m_raux, m_rdata);
            end
          end
        end
        chk("ack_onehot", $onehot0(m_ack), 1);
        if (cnt_chk_en) chk("cnt0", dut.g_master[0].u_credit.cnt_reg, sb[0].size());
        if (wb_stb && !wb_stall) begin
          if (req_exp.size() == 0) chk("req_unexpected", 1, 0);
          else begin
            r = req_exp.pop_front();
            chk("req_id", wb_aux[0], r.id);
            chk("req_addr", wb_addr, r.addr);
          end
          p.tag = wb_aux; p.addr = wb_addr;
          pending.push_back(p);
        end
        for (int k = 0; k < 2; k++) begin
          if (m_stb[k] && !m_stall[k]) begin
            acc[k] = 1'b1;
            if (grant_chk_en && m_stb == 2'b11) chk("rr_order", k, 1 - last_grant);
            last_grant = k;
            e.aux = m_aux[k]; e.data = rd_data(m_addr[k]);
            sb[k].push_back(e);
            r.id = 1'(k); r.addr = m_addr[k];
            req_exp.push_back(r);
          end
        end
        if (acc[0] && wb_ack && !wb_raux[0]) coincide++;
      end
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        if (acc[k]) begin
          issued[k]++;
          m_addr[k] = m_addr[k] + 16'd1;
          m_aux[k]  = m_aux[k] + 8'd1;
        end
      end
      wb_ack = 1'b0;
      if (!rst && acks_sent < ack_limit && pending.size() > 0) begin
        p = pending.pop_front();
        wb_ack = 1'b1; wb_raux = p.tag; wb_rdata = rd_data(p.addr);
        acks_sent++;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (n < 300 && !(issued[0] == target[0] && issued[1] == target[1] &&
           sb[0].size() == 0 && sb[1].size() == 0 && pending.size() == 0 &&
           req_exp.size() == 0 && !wb_stb)) begin
      @(negedge clk); n++;
    end
    chk(tag, n < 300, 1);
    @(negedge clk);
    chk({tag, "_cyc_low"}, wb_cyc, 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base, snap, n;
    logic [15:0] hold_addr;
    logic [8:0]  hold_aux;
    #1;
    chk("rst_stall", m_stall, 2'b11);
    chk("rst_ack", m_ack, 0);
    chk("rst_stb", wb_stb, 0);
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_fields", {wb_we, wb_addr, wb_data, wb_sel, wb_aux}, 0);
    chk("rst_rdata", {m_rdata, m_raux}, 0);
    repeat (3) step();
    rst = 1'b0;

    // Interleave: both masters streaming, acks unthrottled.
    step();
    grant_chk_en = 1; ack_limit = 1000000; m_cyc = 2'b11;
    target[0] += 6; target[1] += 6;
    wait_idle("t1_drain");
    grant_chk_en = 0;
    chk("t1_acks_m0", ack_total[0], 6);
    chk("t1_acks_m1", ack_total[1], 6);

    // Credit limit with acks withheld.
    step();
    ack_limit = acks_sent; base = issued[0]; target[0] += 6;
    repeat (8) step();
    @(negedge clk);
    chk("credit_issued", issued[0] - base, 4);
    chk("credit_stall", {m_stb[0], m_stall[0]}, 2'b11);
    step();
    ack_limit = ack_limit + 1;
    repeat (6) step();
    @(negedge clk);
    chk("credit_one_more", issued[0] - base, 5);
    chk("credit_stall2", m_stall[0], 1);
    step();
    ack_limit = acks_sent + 1000000;
    wait_idle("t2_drain");

    // Abort with three outstanding on M1.
    step();
    ack_limit = acks_sent; base = issued[1]; target[1] += 3;
    repeat (6) step();
    chk("abort_issued", issued[1] - base, 3);
    m_cyc = 2'b01; flush_gen++; snap = ack_total[1];
    repeat (2) step();
    m_cyc = 2'b11; target[1] += 1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_stall", {m_stb[1], m_stall[1]}, 2'b11);
    end
    step();
    ack_limit = acks_sent + 1000000;
    wait_idle("t3_drain");
    chk("abort_acks", ack_total[1] - snap, 1);

    // Simultaneous load/ack on M0, then downstream stall hold.
    step();
    cnt_chk_en = 1; target[0] += 10;
    wait_idle("t4_drain");
    cnt_chk_en = 0;
    chk("coincide_seen", coincide > 0, 1);
    step();
    wb_stall = 1'b1; target[0] += 2;
    n = 0;
    while (n < 20 && !wb_stb) begin @(negedge clk); n++; end
    chk("hold_stb_seen", n < 20, 1);
    hold_addr = wb_addr; hold_aux = wb_aux;
    repeat (5) begin
      @(negedge clk);
      chk("hold_stb", wb_stb, 1);
      chk("hold_addr", wb_addr, hold_addr);
      chk("hold_aux", wb_aux, hold_aux);
      chk("hold_mstall", m_stall[0], 1);
    end
    step();
    wb_stall = 1'b0;
    wait_idle("t4b_drain");

    // Reset with two requests outstanding.
    step();
    ack_limit = acks_sent; target[0] += 2;
    repeat (5) step();
    chk("pre_reset_cyc", wb_cyc, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_stall", m_stall, 2'b11);
    chk("mid_rst_ack", m_ack, 0);
    chk("mid_rst_stb", wb_stb, 0);
    chk("mid_rst_cyc", wb_cyc, 0);
    chk("mid_rst_aux", wb_aux, 0);
    repeat (2) step();
    rst = 1'b0;
    ack_limit = acks_sent + 1000000;
    m_cyc = 2'b11; target[0] += 1; target[1] += 1;
    @(negedge clk);
    chk("post_rst_m0_first", m_stall, 2'b10);
    wait_idle("t5_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
